// File: rtl/sd_spi_cmd_engine.sv
// sd_spi_cmd_engine: SD-card SPI-mode power-up, wake-up and single command/response engine.
module sd_spi_cmd_engine #(
  parameter int CLK_HZ         = 100000000,
  parameter int SLOW_HZ        = 400000,
  parameter int FAST_HZ        = 25000000,
  parameter int POWER_DELAY    = 1000000,
  parameter int WAKE_CYCLES    = 80,
  parameter int NCR_MAX        = 16,
  parameter int RESP_MAX_BYTES = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [5:0]                  cmd_index,
  input  logic [31:0]                 cmd_arg,
  input  logic [2:0]                  resp_len,
  input  logic                        fast_mode,
  output logic                        resp_valid,
  output logic [8*RESP_MAX_BYTES-1:0] resp_data,
  output logic                        resp_timeout,
  output logic                        init_done,
  output logic                        sd_cclk,
  output logic                        sd_cmd,
  input  logic                        sd_data0,
  output logic                        sd_cs,
  output logic                        sd_reset
);
  localparam int SLOW_DIV = CLK_HZ / (2 * SLOW_HZ);
  localparam int FAST_DIV = CLK_HZ / (2 * FAST_HZ);
  localparam int DW = $clog2(SLOW_DIV > FAST_DIV ? SLOW_DIV : FAST_DIV) + 1;
  localparam int PW = $clog2(POWER_DELAY + 1);
  localparam int BW = $clog2((WAKE_CYCLES > 48 ? WAKE_CYCLES : 48) + 1);
  localparam int NW = $clog2((NCR_MAX > RESP_MAX_BYTES ? NCR_MAX : RESP_MAX_BYTES) + 1);
  localparam int RW = 8 * RESP_MAX_BYTES;
  localparam logic [DW-1:0] SLOW_H = DW'(SLOW_DIV - 1);
  localparam logic [DW-1:0] FAST_H = DW'(FAST_DIV - 1);

  typedef enum logic [3:0] {PWR_OFF, PWR_WAIT, WAKE, IDLE, SEND, POLL, READ, TRAIL, DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic            sclk_q, sclk_d;
  logic [PW-1:0]   pwr_q, pwr_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [NW-1:0]   byte_q, byte_d;
  logic [47:0]     sh_q, sh_d;
  logic [6:0]      crc_q, crc_d;
  logic [7:0]      rx_q, rx_d;
  logic [RW-1:0]   resp_q, resp_d;
  logic            to_q, to_d;
  logic [2:0]      len_q, len_d;
  logic            fast_q, fast_d;
  logic            init_q, init_d;
  logic            run, tick, rise, fall, byte_end, crc_fb;
  logic [6:0]      crc_nx;
  logic [2:0]      len_c;

  assign run      = state_q inside {WAKE, SEND, POLL, READ, TRAIL};
  assign tick     = run && div_q == (fast_q ? FAST_H : SLOW_H);
  assign rise     = tick && !sclk_q;
  assign fall     = tick && sclk_q;
  assign byte_end = fall && bit_q == BW'(7);
  assign crc_fb   = sh_q[47] ^ crc_q[6];
  assign crc_nx   = {crc_q[5:0], 1'b0} ^ {3'b000, crc_fb, 2'b00, crc_fb};
  assign len_c    = (resp_len == 3'd0) ? 3'd1 : (int'(resp_len) > RESP_MAX_BYTES) ? 3'(RESP_MAX_BYTES) : resp_len;

  always_comb begin
    state_d = state_q;
    div_d   = run ? (tick ? '0 : div_q + 1'b1) : '0;
    sclk_d  = run ? sclk_q ^ tick : 1'b0;
    pwr_d   = pwr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    crc_d   = crc_q;
    rx_d    = rise ? {rx_q[6:0], sd_data0} : rx_q;
    resp_d  = resp_q;
    to_d    = to_q;
    len_d   = len_q;
    fast_d  = fast_q;
    init_d  = init_q;
    case (state_q)
      PWR_OFF: state_d = PWR_WAIT;
      PWR_WAIT: begin
        pwr_d = pwr_q + 1'b1;
        if (pwr_q == PW'(POWER_DELAY - 1)) state_d = WAKE;
      end
      WAKE: if (fall) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(WAKE_CYCLES - 1)) begin
          state_d = IDLE;
          init_d  = 1'b1;
          bit_d   = '0;
        end
      end
      IDLE: if (cmd_valid) begin
        state_d = SEND;
        sh_d    = {2'b01, cmd_index, cmd_arg, 8'h00};
        crc_d   = '0;
        bit_d   = '0;
        byte_d  = '0;
        resp_d  = '0;
        to_d    = 1'b0;
        len_d   = len_c;
        fast_d  = fast_mode;
      end
      SEND: if (fall) begin
        // CRC is folded in as each of the first 40 bits leaves; it then replaces the tail
        bit_d = bit_q + 1'b1;
        sh_d  = sh_q << 1;
        if (bit_q < BW'(40)) crc_d = crc_nx;
        if (bit_q == BW'(39)) sh_d = {crc_nx, 1'b1, 40'h0};
        if (bit_q == BW'(47)) begin
          state_d = POLL;
          bit_d   = '0;
        end
      end
      POLL: if (fall) begin
        bit_d = bit_q + 1'b1;
        if (byte_end) begin
          bit_d = '0;
          if (!rx_q[7]) begin
            resp_d  = (resp_q << 8) | RW'(rx_q);
            byte_d  = NW'(1);
            state_d = (len_q == 3'd1) ? TRAIL : READ;
          end else if (byte_q == NW'(NCR_MAX - 1)) begin
            state_d = TRAIL;
            to_d    = 1'b1;
            resp_d  = '1;
          end else byte_d = byte_q + 1'b1;
        end
      end
      READ: if (fall) begin
        bit_d = bit_q + 1'b1;
        if (byte_end) begin
          bit_d  = '0;
          resp_d = (resp_q << 8) | RW'(rx_q);
          byte_d = byte_q + 1'b1;
          if (byte_q + 1'b1 == NW'(len_q)) state_d = TRAIL;
        end
      end
      TRAIL: if (fall) begin
        bit_d = bit_q + 1'b1;
        if (byte_end) begin
          bit_d   = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = PWR_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PWR_OFF;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      pwr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      crc_q   <= '0;
      rx_q    <= '0;
      resp_q  <= '0;
      to_q    <= 1'b0;
      len_q   <= '0;
      fast_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      pwr_q   <= pwr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      crc_q   <= crc_d;
      rx_q    <= rx_d;
      resp_q  <= resp_d;
      to_q    <= to_d;
      len_q   <= len_d;
      fast_q  <= fast_d;
      init_q  <= init_d;
    end
  end

  assign cmd_ready    = state_q == IDLE;
  assign resp_valid   = state_q == DONE;
  assign resp_data    = resp_q;
  assign resp_timeout = to_q;
  assign init_done    = init_q;
  assign sd_cclk      = sclk_q;
  assign sd_cmd       = (state_q == SEND) ? sh_q[47] : 1'b1;
  assign sd_cs        = !(state_q inside {SEND, POLL, READ});
  assign sd_reset     = state_q == PWR_OFF;
endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// tb_sd_spi_cmd_engine: directed and randomised commands against a byte-level SD card model.
module tb_sd_spi_cmd_engine;
  localparam int PD = 200;
  localparam int NCR = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [2:0]  resp_len = '0;
  logic        fast_mode = 1'b0;
  logic        resp_valid;
  logic [39:0] resp_data;
  logic        resp_timeout;
  logic        init_done;
  logic        sd_cclk, sd_cmd, sd_cs, sd_reset;
  logic        miso = 1'b1;

  int n_assert = 0;
  int n_fail = 0;

  sd_spi_cmd_engine #(
    .CLK_HZ(100000000), .SLOW_HZ(10000000), .FAST_HZ(25000000),
    .POWER_DELAY(PD), .WAKE_CYCLES(80), .NCR_MAX(NCR), .RESP_MAX_BYTES(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_len(resp_len), .fast_mode(fast_mode),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_timeout(resp_timeout),
    .init_done(init_done), .sd_cclk(sd_cclk), .sd_cmd(sd_cmd), .sd_data0(miso),
    .sd_cs(sd_cs), .sd_reset(sd_reset)
  );

  always #5 clk = ~clk;

  // Card model: collects the 48-bit frame on SCLK rises, then streams its reply bytes on falls.
  logic [7:0]  card_b [0:31];
  int          card_n = 0;
  logic [47:0] frame = '0;
  int          nbits = 0;
  int          mi = 0;

  always @(sd_cclk or sd_cs) begin
    if (sd_cs) begin
      nbits = 0;
      mi = 0;
      miso = 1'b1;
    end else if (sd_cclk) begin
      if (nbits < 48) begin
        frame = {frame[46:0], sd_cmd};
        nbits++;
      end
    end else if (nbits >= 48) begin
      miso = (mi / 8 < card_n) ? card_b[mi / 8][7 - mi % 8] : 1'b1;
      mi++;
    end
  end

  // SCLK timing monitor
  int   cyc = 0, last_edge = 0, cmd_half = 0, wake_half = 0, wake_rises = 0;
  int   first_rise = -1, pwr_mark = 0, trail_rises = 0;
  bit   seen_wake = 1'b0;
  logic prev_cclk = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (sd_reset) begin
      pwr_mark = cyc;
      first_rise = -1;
      wake_rises = 0;
      seen_wake = 1'b0;
    end
    if (sd_cclk !== prev_cclk) begin
      if (!init_done && seen_wake) wake_half = cyc - last_edge;
      if (!init_done) seen_wake = 1'b1;
      if (!sd_cs) cmd_half = cyc - last_edge;
      if (sd_cclk) begin
        if (first_rise < 0) first_rise = cyc;
        if (!init_done) wake_rises++;
        if (sd_cs && init_done) trail_rises++;
      end
      last_edge = cyc;
      prev_cclk = sd_cclk;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'h00};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [7:0] bytev(input int i);
    return (i < card_n) ? card_b[i] : 8'hFF;
  endfunction

  task automatic load(input logic [47:0] v, input int n);
    card_n = n;
    for (int i = 0; i < n; i++) card_b[i] = v[8 * (n - 1 - i) +: 8];
  endtask

  task automatic rand_card(input int npad);
    card_n = npad + 6;
    for (int i = 0; i < card_n; i++) card_b[i] = 8'($urandom);
    for (int i = 0; i < npad; i++) card_b[i] = card_b[i] | 8'h80;
    card_b[npad] = card_b[npad] & 8'h7F;
  endtask

  task automatic powerup(input string tag);
    int w;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_pwr_on"}, 64'(sd_reset), 64'(0));
    chk({tag, "_cs_idle"}, 64'(sd_cs), 64'(1));
    w = 0;
    while (!init_done && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_init_done"}, 64'(init_done), 64'(1));
    chk({tag, "_wake_rises"}, 64'(wake_rises), 64'(80));
    chk({tag, "_wake_half"}, 64'(wake_half), 64'(5));
    chk({tag, "_pwr_delay"}, 64'(first_rise - pwr_mark >= PD && first_rise - pwr_mark <= PD + 14), 64'(1));
    chk({tag, "_ready"}, 64'(cmd_ready), 64'(1));
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [2:0] len, input logic fm);
    int l, n, p, h, lat, tb0;
    logic [39:0] exp;
    logic [47:0] exp_frame;
    logic [7:0] b;
    bit found;
    l = (len == 3'd0) ? 1 : (len > 3'd5) ? 5 : int'(len);
    found = 1'b0;
    n = 0;
    for (int i = 0; i < NCR; i++) begin
      b = bytev(i);
      if (!found && !b[7]) begin
        found = 1'b1;
        n = i + 1;
      end
    end
    exp = '0;
    if (found) for (int j = 0; j < l; j++) exp = {exp[31:0], bytev(n - 1 + j)};
    else exp = '1;
    p = found ? 48 + 8 * n + 8 * (l - 1) + 8 : 48 + 8 * NCR + 8;
    h = fm ? 2 : 5;
    exp_frame = {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
    @(negedge clk);
    lat = 0;
    while (!cmd_ready && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_ready"}, 64'(cmd_ready), 64'(1));
    cmd_index = idx;
    cmd_arg = arg;
    resp_len = len;
    fast_mode = fm;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    fast_mode = ~fm;
    resp_len = 3'($urandom);
    cmd_arg = $urandom;
    chk({tag, "_busy"}, 64'(cmd_ready), 64'(0));
    tb0 = trail_rises;
    lat = 0;
    while (!resp_valid && lat < 20000) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, 64'(resp_valid), 64'(1));
    chk({tag, "_frame"}, 64'(frame), 64'(exp_frame));
    chk({tag, "_data"}, 64'(resp_data), 64'(exp));
    chk({tag, "_timeout"}, 64'(resp_timeout), 64'(!found));
    chk({tag, "_latency"}, 64'(lat >= p * 2 * h && lat <= p * 2 * h + 3), 64'(1));
    chk({tag, "_half"}, 64'(cmd_half), 64'(h));
    chk({tag, "_trail"}, 64'(trail_rises - tb0), 64'(8));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(resp_valid), 64'(0));
    chk({tag, "_idle"}, 64'(cmd_ready), 64'(1));
    chk({tag, "_hold"}, 64'(resp_data), 64'(exp));
  endtask

  initial begin
    int w;
    repeat (10) @(negedge clk);
    chk("rst_sd_reset", 64'(sd_reset), 64'(1));
    chk("rst_cs", 64'(sd_cs), 64'(1));
    chk("rst_cmd", 64'(sd_cmd), 64'(1));
    chk("rst_cclk", 64'(sd_cclk), 64'(0));
    chk("rst_ready", 64'(cmd_ready), 64'(0));
    chk("rst_init", 64'(init_done), 64'(0));
    chk("rst_valid", 64'(resp_valid), 64'(0));
    chk("rst_data", 64'(resp_data), 64'(0));
    powerup("pwr0");

    load(48'hFF01, 2);
    run_cmd("cmd0", 6'd0, 32'h0, 3'd1, 1'b0);
    chk("cmd0_frame_const", 64'(frame), 64'h400000000095);
    load(48'hFF01000001AA, 6);
    run_cmd("cmd8", 6'd8, 32'h1AA, 3'd5, 1'b0);
    chk("cmd8_crc", 64'(frame[7:0]), 64'h87);
    chk("cmd8_data_const", 64'(resp_data), 64'h01000001AA);
    load(48'h01, 1);
    run_cmd("cmd55", 6'd55, 32'h0, 3'd1, 1'b1);
    chk("cmd55_crc", 64'(frame[7:0]), 64'h65);
    load(48'hFFFF00, 3);
    run_cmd("acmd41", 6'd41, 32'h40000000, 3'd1, 1'b1);
    chk("acmd41_crc", 64'(frame[7:0]), 64'h77);
    load(48'hFF00C0FF8000, 6);
    run_cmd("cmd58", 6'd58, 32'h0, 3'd5, 1'b1);
    chk("cmd58_crc", 64'(frame[7:0]), 64'hFD);
    chk("cmd58_data_const", 64'(resp_data), 64'h00C0FF8000);
    card_n = 0;
    run_cmd("tmo", 6'd17, 32'h1234, 3'd1, 1'b1);
    chk("tmo_flag", 64'(resp_timeout), 64'(1));
    rand_card(15);
    run_cmd("ncr_last", 6'd13, $urandom, 3'd2, 1'b1);
    rand_card(2);
    run_cmd("len0", 6'($urandom), $urandom, 3'd0, 1'b0);
    rand_card(1);
    run_cmd("len7", 6'($urandom), $urandom, 3'd7, 1'b1);
    for (int k = 0; k < 6; k++) begin
      rand_card($urandom_range(0, 17));
      run_cmd("rnd", 6'($urandom), $urandom, 3'($urandom), 1'($urandom));
    end

    load(48'hFF01, 2);
    @(negedge clk);
    cmd_index = 6'd0;
    cmd_arg = 32'h0;
    resp_len = 3'd1;
    fast_mode = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (60) @(negedge clk);
    chk("mid_cs_low", 64'(sd_cs), 64'(0));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_cs", 64'(sd_cs), 64'(1));
    chk("mid_sd_reset", 64'(sd_reset), 64'(1));
    chk("mid_init", 64'(init_done), 64'(0));
    chk("mid_ready", 64'(cmd_ready), 64'(0));
    chk("mid_cclk", 64'(sd_cclk), 64'(0));
    repeat (5) @(negedge clk);
    powerup("pwr1");
    run_cmd("cmd0_again", 6'd0, 32'h0, 3'd1, 1'b0);
    w = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
